// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header: strips H = byte_extract_cnt+1 leading bytes of each
// AXI-Stream packet onto a header side channel and realigns the remaining
// payload so its first byte sits in the MSB lane.
// Optional feature macro: AXIS_EXTRACT_SHORT_ERR_EN adds the err_short output.
module axi_stream_extract_header #(
   parameter int DATA_WD = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic [DATA_WD-1:0]           data_in,
   input  logic [DATA_WD/8-1:0]         keep_in,
   input  logic                         last_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [DATA_WD-1:0]           data_out,
   output logic [DATA_WD/8-1:0]         keep_out,
   output logic                         last_out,
   input  logic                         valid_cfg,
   output logic                         ready_cfg,
   input  logic [$clog2(DATA_WD/8)-1:0] byte_extract_cnt,
   output logic                         valid_header,
   input  logic                         ready_header,
   output logic [DATA_WD-1:0]           data_header,
   output logic [DATA_WD/8-1:0]         keep_header
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
   ,
   output logic                         err_short
`endif
);
   localparam int B  = DATA_WD / 8;
   localparam int CW = $clog2(B);
   localparam int SW = $clog2(DATA_WD) + 1;

   typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

   state_t               state_q, state_d;
   logic [CW:0]          h_q, h_d;
   logic [DATA_WD-1:0]   res_data_q, res_data_d;
   logic [B-1:0]         res_keep_q, res_keep_d;
   logic                 valid_out_q, valid_out_d;
   logic [DATA_WD-1:0]   data_out_q, data_out_d;
   logic [B-1:0]         keep_out_q, keep_out_d;
   logic                 last_out_q, last_out_d;
   logic                 valid_header_q, valid_header_d;
   logic [DATA_WD-1:0]   data_header_q, data_header_d;
   logic [B-1:0]         keep_header_q, keep_header_d;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
   logic                 err_short_q, err_short_d;
`endif

   logic [SW-1:0]        sh_h, sh_r;
   logic [CW:0]          kr;
   logic                 out_free;
   logic [B-1:0]         hdr_keep, new_res_keep, merge_keep;
   logic [DATA_WD-1:0]   new_res_data, merge_data;

   function automatic logic [DATA_WD-1:0] lane_mask(input logic [B-1:0] k);
      logic [DATA_WD-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < B; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   // Header bytes sit in the top H lanes; the residue is everything after them
   // shifted up to the MSB. A merged beat is residue OR the top H incoming bytes,
   // and with contiguous keep the union of the two keeps is exactly top (B-H)+n.
   assign sh_h         = SW'(h_q) << 3;
   assign sh_r         = SW'(DATA_WD) - sh_h;
   assign kr           = (CW+1)'(B) - h_q;
   assign out_free     = !valid_out_q || ready_out;
   assign hdr_keep     = keep_in >> kr;
   assign new_res_keep = keep_in << h_q;
   assign new_res_data = data_in << sh_h;
   assign merge_keep   = res_keep_q | hdr_keep;
   assign merge_data   = res_data_q | (data_in >> sh_r);

   // Next-state, handshakes and register loads
   always_comb begin
      state_d        = state_q;
      h_d            = h_q;
      res_data_d     = res_data_q;
      res_keep_d     = res_keep_q;
      valid_out_d    = valid_out_q;
      data_out_d     = data_out_q;
      keep_out_d     = keep_out_q;
      last_out_d     = last_out_q;
      valid_header_d = valid_header_q;
      data_header_d  = data_header_q;
      keep_header_d  = keep_header_q;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      err_short_d    = 1'b0;
`endif
      ready_in       = 1'b0;
      ready_cfg      = 1'b0;

      if (valid_out_q && ready_out) valid_out_d = 1'b0;
      if (valid_header_q && ready_header) valid_header_d = 1'b0;

      case (state_q)
         IDLE: begin
            ready_cfg = 1'b1;
            if (valid_cfg) begin
               h_d     = {1'b0, byte_extract_cnt} + (CW+1)'(1);
               state_d = HDR;
            end
         end
         HDR: begin
            ready_in = !valid_header_q && out_free;
            if (valid_in && ready_in) begin
               valid_header_d = 1'b1;
               keep_header_d  = hdr_keep;
               data_header_d  = (data_in >> sh_r) & lane_mask(hdr_keep);
               res_data_d     = new_res_data;
               res_keep_d     = new_res_keep;
               if (last_in) begin
                  state_d = IDLE;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
                  err_short_d = (hdr_keep != ({B{1'b1}} >> kr));
`endif
                  if (|new_res_keep) begin
                     valid_out_d = 1'b1;
                     data_out_d  = new_res_data & lane_mask(new_res_keep);
                     keep_out_d  = new_res_keep;
                     last_out_d  = 1'b1;
                  end
               end else begin
                  state_d = BODY;
               end
            end
         end
         BODY: begin
            ready_in = out_free;
            if (valid_in && ready_in) begin
               valid_out_d = 1'b1;
               data_out_d  = merge_data & lane_mask(merge_keep);
               keep_out_d  = merge_keep;
               last_out_d  = 1'b0;
               res_data_d  = new_res_data;
               res_keep_d  = new_res_keep;
               if (last_in) begin
                  // n > H leaves bytes after the full beat: one more beat from FLUSH
                  if (|new_res_keep) begin
                     state_d = FLUSH;
                  end else begin
                     last_out_d = 1'b1;
                     state_d    = IDLE;
                  end
               end
            end
         end
         FLUSH: begin
            if (out_free) begin
               valid_out_d = 1'b1;
               data_out_d  = res_data_q & lane_mask(res_keep_q);
               keep_out_d  = res_keep_q;
               last_out_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any partial packet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         h_q            <= '0;
         res_data_q     <= '0;
         res_keep_q     <= '0;
         valid_out_q    <= 1'b0;
         data_out_q     <= '0;
         keep_out_q     <= '0;
         last_out_q     <= 1'b0;
         valid_header_q <= 1'b0;
         data_header_q  <= '0;
         keep_header_q  <= '0;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
         err_short_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         h_q            <= h_d;
         res_data_q     <= res_data_d;
         res_keep_q     <= res_keep_d;
         valid_out_q    <= valid_out_d;
         data_out_q     <= data_out_d;
         keep_out_q     <= keep_out_d;
         last_out_q     <= last_out_d;
         valid_header_q <= valid_header_d;
         data_header_q  <= data_header_d;
         keep_header_q  <= keep_header_d;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
         err_short_q    <= err_short_d;
`endif
      end
   end

   assign valid_out    = valid_out_q;
   assign data_out     = data_out_q;
   assign keep_out     = keep_out_q;
   assign last_out     = last_out_q;
   assign valid_header = valid_header_q;
   assign data_header  = data_header_q;
   assign keep_header  = keep_header_q;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
   assign err_short    = err_short_q;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Testbench for axi_stream_extract_header (B = 4): table vectors, hand-written
// backpressure / reset sequences and randomized packets against a byte-level model.
module tb_axi_stream_extract_header;
   localparam int TMO = 200;

   typedef struct { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
   typedef struct { logic [31:0] d; logic [3:0] k; } hdr_t;
   typedef struct {
      int h; int nb; logic [3:0][31:0] d; logic [3:0] lk;
      logic [31:0] hd; logic [3:0] hk; int np;
      logic [2:0][31:0] pd; logic [2:0][3:0] pk; int err;
   } vec_t;

   logic        clk, rst_n;
   logic        valid_in, ready_in, last_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        valid_out, ready_out, last_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        valid_cfg, ready_cfg;
   logic [1:0]  byte_extract_cnt;
   logic        valid_header, ready_header;
   logic [31:0] data_header;
   logic [3:0]  keep_header;
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
   logic        err_short;
`endif

   int n_pass, n_total, got_err, bp_mode, exp_err;
   beat_t got_pay[$];
   hdr_t  got_hdr[$];
   beat_t exp_pay[$];
   logic [31:0] exp_hdr_d;
   logic [3:0]  exp_hdr_k;
   logic [7:0]  pkt_b[$];
   beat_t mon_b;
   hdr_t  mon_h;
   vec_t  tv[7];

   axi_stream_extract_header #(.DATA_WD(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .valid_cfg(valid_cfg), .ready_cfg(ready_cfg), .byte_extract_cnt(byte_extract_cnt),
      .valid_header(valid_header), .ready_header(ready_header), .data_header(data_header), .keep_header(keep_header)
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      , .err_short(err_short)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Sink readiness: 0 = always ready, 1 = random, 2 = driven by the test
   always @(posedge clk) begin
      #1;
      if (bp_mode == 0) begin
         ready_out = 1'b1; ready_header = 1'b1;
      end else if (bp_mode == 1) begin
         ready_out    = ($urandom_range(0, 3) != 0);
         ready_header = ($urandom_range(0, 3) != 0);
      end
   end

   // Collect every beat that completes a handshake on the next rising edge
   always @(negedge clk) begin
      if (rst_n && valid_out && ready_out) begin
         mon_b.d = data_out; mon_b.k = keep_out; mon_b.l = last_out;
         got_pay.push_back(mon_b);
      end
      if (rst_n && valid_header && ready_header) begin
         mon_h.d = data_header; mon_h.k = keep_header;
         got_hdr.push_back(mon_h);
      end
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      if (err_short) begin
         got_err++;
         check("err_short_with_valid_header", {63'd0, valid_header}, 64'd1);
      end
`endif
   end

   task automatic send_cfg(input int h);
      int t;
      t = 0;
      valid_cfg = 1'b1; byte_extract_cnt = 2'(h - 1);
      @(negedge clk);
      while (!ready_cfg && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin n_total++; $display("FAIL cfg_timeout: ready_cfg got 0, required 1"); end
      @(posedge clk); #1;
      valid_cfg = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int t;
      t = 0;
      valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
      @(negedge clk);
      while (!ready_in && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin n_total++; $display("FAIL beat_timeout: ready_in got 0, required 1"); end
      @(posedge clk); #1;
      valid_in = 1'b0; last_in = 1'b0;
   endtask

   // Reference: header = first H bytes right-justified, payload = remaining bytes packed MSB-first
   task automatic model(input int h);
      beat_t b;
      int n;
      n = pkt_b.size();
      exp_hdr_d = '0; exp_hdr_k = '0; exp_pay.delete();
      for (int i = 0; i < h && i < n; i++) begin
         exp_hdr_d[(h-1-i)*8 +: 8] = pkt_b[i];
         exp_hdr_k[h-1-i] = 1'b1;
      end
      exp_err = (n < h) ? 1 : 0;
      for (int i = h; i < n; i += 4) begin
         b.d = '0; b.k = '0; b.l = (i + 4 >= n);
         for (int k = 0; k < 4; k++)
            if (i + k < n) begin b.d[(3-k)*8 +: 8] = pkt_b[i+k]; b.k[3-k] = 1'b1; end
         exp_pay.push_back(b);
      end
   endtask

   task automatic load_vec(input int i);
      beat_t b;
      exp_hdr_d = tv[i].hd; exp_hdr_k = tv[i].hk; exp_err = tv[i].err;
      exp_pay.delete();
      for (int j = 0; j < tv[i].np; j++) begin
         b.d = tv[i].pd[j]; b.k = tv[i].pk[j]; b.l = (j == tv[i].np - 1);
         exp_pay.push_back(b);
      end
   endtask

   task automatic expect_pkt(input string name);
      int t;
      t = 0;
      while ((got_hdr.size() < 1 || got_pay.size() < exp_pay.size()) && t < TMO) begin
         @(posedge clk); t++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({name, "_hdr_count"}, got_hdr.size(), 1);
      if (got_hdr.size() > 0) begin
         check({name, "_hdr_data"}, got_hdr[0].d, exp_hdr_d);
         check({name, "_hdr_keep"}, got_hdr[0].k, exp_hdr_k);
      end
      check({name, "_pay_count"}, got_pay.size(), exp_pay.size());
      for (int i = 0; i < exp_pay.size() && i < got_pay.size(); i++) begin
         check($sformatf("%s_pay%0d_data", name, i), got_pay[i].d, exp_pay[i].d);
         check($sformatf("%s_pay%0d_keep", name, i), got_pay[i].k, exp_pay[i].k);
         check($sformatf("%s_pay%0d_last", name, i), got_pay[i].l, exp_pay[i].l);
      end
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      check({name, "_err_short_count"}, got_err, exp_err);
`endif
      got_hdr.delete(); got_pay.delete(); got_err = 0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid_out"}, valid_out, 0);
      check({name, "_data_out"}, data_out, 0);
      check({name, "_keep_out"}, keep_out, 0);
      check({name, "_last_out"}, last_out, 0);
      check({name, "_valid_header"}, valid_header, 0);
      check({name, "_data_header"}, data_header, 0);
      check({name, "_keep_header"}, keep_header, 0);
      check({name, "_ready_in"}, ready_in, 0);
      check({name, "_ready_cfg"}, ready_cfg, 1);
`ifdef AXIS_EXTRACT_SHORT_ERR_EN
      check({name, "_err_short"}, err_short, 0);
`endif
   endtask

   task automatic set_vec(input int i, input int h, input int nb, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [3:0] lk, input logic [31:0] hd, input logic [3:0] hk,
                          input int np, input logic [31:0] p0, input logic [3:0] k0, input logic [31:0] p1,
                          input logic [3:0] k1, input logic [31:0] p2, input logic [3:0] k2, input int err);
      tv[i].h = h; tv[i].nb = nb; tv[i].d = {32'h0, d2, d1, d0}; tv[i].lk = lk;
      tv[i].hd = hd; tv[i].hk = hk; tv[i].np = np;
      tv[i].pd = {p2, p1, p0}; tv[i].pk = {k2, k1, k0}; tv[i].err = err;
   endtask

   task automatic run_random(input int count);
      int h, nb, nl, n;
      logic [31:0] d;
      logic [3:0] k;
      bp_mode = 1;
      for (int p = 0; p < count; p++) begin
         h = $urandom_range(1, 4); nb = $urandom_range(1, 4); nl = $urandom_range(1, 4);
         n = 4 * (nb - 1) + nl;
         pkt_b.delete();
         for (int i = 0; i < n; i++) pkt_b.push_back(8'($urandom));
         model(h);
         send_cfg(h);
         for (int j = 0; j < nb; j++) begin
            d = $urandom; k = '0;
            for (int q = 0; q < 4; q++)
               if (4*j + q < n) begin d[(3-q)*8 +: 8] = pkt_b[4*j+q]; k[3-q] = 1'b1; end
            send_beat(d, k, j == nb - 1);
         end
         expect_pkt($sformatf("rand%0d", p));
      end
      bp_mode = 0;
   endtask

   initial begin
      //           h nb  beat0         beat1         beat2         lastkeep hdr_data      hdr_keep np pay0/keep0          pay1/keep1          pay2/keep2         err
      set_vec(0, 2, 3, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 4'b1100, 32'h0000AABB, 4'b0011, 2, 32'hCCDD1122, 4'hF, 32'h33445566, 4'hF, 32'h0, 4'h0, 0);
      set_vec(1, 2, 3, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 4'b1110, 32'h0000AABB, 4'b0011, 3, 32'hCCDD1122, 4'hF, 32'h33445566, 4'hF, 32'h77000000, 4'h8, 0);
      set_vec(2, 1, 1, 32'hAABBCCDD, 32'h0, 32'h0, 4'b1111, 32'h000000AA, 4'b0001, 1, 32'hBBCCDD00, 4'hE, 32'h0, 4'h0, 32'h0, 4'h0, 0);
      set_vec(3, 4, 1, 32'hAABBCCDD, 32'h0, 32'h0, 4'b1100, 32'hAABB0000, 4'b1100, 0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0, 4'h0, 1);
      set_vec(4, 3, 2, 32'h0A0B0C0D, 32'h10203040, 32'h0, 4'b1000, 32'h000A0B0C, 4'b0111, 1, 32'h0D100000, 4'hC, 32'h0, 4'h0, 32'h0, 4'h0, 0);
      set_vec(5, 4, 2, 32'h01020304, 32'h05060708, 32'h0, 4'b1111, 32'h01020304, 4'b1111, 1, 32'h05060708, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0, 0);
      set_vec(6, 1, 2, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0, 4'b1000, 32'h000000A1, 4'b0001, 1, 32'hA2A3A4B1, 4'hF, 32'h0, 4'h0, 32'h0, 4'h0, 0);

      n_pass = 0; n_total = 0; got_err = 0; bp_mode = 0;
      rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_cfg = 1'b0; byte_extract_cnt = '0; ready_out = 1'b1; ready_header = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         load_vec(i);
         send_cfg(tv[i].h);
         for (int j = 0; j < tv[i].nb; j++)
            send_beat(tv[i].d[j], (j == tv[i].nb - 1) ? tv[i].lk : 4'hF, j == tv[i].nb - 1);
         expect_pkt($sformatf("vec%0d", i));
      end

      // Backpressure on both outputs: held beat and header must stay put
      bp_mode = 2; ready_out = 1'b0; ready_header = 1'b0;
      load_vec(0);
      fork
         begin
            send_cfg(2);
            send_beat(32'hAABBCCDD, 4'hF, 1'b0);
            send_beat(32'h11223344, 4'hF, 1'b0);
            send_beat(32'h55667788, 4'hC, 1'b1);
         end
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!valid_out && t < TMO) begin @(negedge clk); t++; end
            for (int c = 0; c < 5; c++) begin
               check("bp_valid_out", valid_out, 1);
               check("bp_data_out", {data_out, keep_out, 3'b000, last_out}, {32'hCCDD1122, 4'hF, 4'h0});
               check("bp_ready_in", ready_in, 0);
               check("bp_header", {valid_header, data_header, keep_header}, {1'b1, 32'h0000AABB, 4'b0011});
               @(negedge clk);
            end
            bp_mode = 0;
         end
      join
      expect_pkt("backpressure");

      // Reset after the second beat, then a clean H=3 packet
      send_cfg(2);
      send_beat(32'hAABBCCDD, 4'hF, 1'b0);
      send_beat(32'h11223344, 4'hF, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      got_hdr.delete(); got_pay.delete(); got_err = 0;
      exp_hdr_d = 32'h00010203; exp_hdr_k = 4'b0111; exp_err = 0;
      exp_pay.delete();
      mon_b.d = 32'h04050607; mon_b.k = 4'hF; mon_b.l = 1'b0; exp_pay.push_back(mon_b);
      mon_b.d = 32'h08090A0B; mon_b.k = 4'hF; mon_b.l = 1'b1; exp_pay.push_back(mon_b);
      send_cfg(3);
      send_beat(32'h01020304, 4'hF, 1'b0);
      send_beat(32'h05060708, 4'hF, 1'b0);
      send_beat(32'h090A0B0C, 4'hE, 1'b1);
      expect_pkt("after_reset");

      run_random(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

- Receive-side counterpart of the header-insertion block.
- Strips a configurable number of leading header bytes from each AXI-Stream packet and presents them on a side channel.
- Realigns the remaining payload so its first byte lands in the MSB lane, and rebuilds `keep`/`last` for the shortened packet.
- Sits at the ingress of a consumer that needs the header separately from the payload.

## Interface
- `DATA_WD`, 32: data width in bits, a multiple of 8. Derived: `B = DATA_WD/8` byte lanes.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in` / `ready_in`  in / out  1 / 1  input stream handshake.
- `data_in`  in  DATA_WD  input data; byte 0 of the stream is in the MSB lane.
- `keep_in`  in  B  byte enables. All ones except on the last beat, where they are contiguous from the MSB (e.g. 1100).
- `last_in`  in  1  marks the final beat of the input packet.
- `valid_out` / `ready_out`  out / in  1 / 1  payload output handshake.
- `data_out`, `keep_out`, `last_out`  out  DATA_WD / B / 1  payload beat, MSB-aligned. Invalid lanes are zero.
- `valid_cfg` / `ready_cfg`  in / out  1 / 1  per-packet configuration handshake.
- `byte_extract_cnt`  in  $clog2(B)  header length minus one, so `H = byte_extract_cnt + 1` (range 1..B).
- `valid_header` / `ready_header`  out / in  1 / 1  header side-channel handshake.
- `data_header`  out  DATA_WD  header bytes, right-justified in the low H lanes. Lanes that were not received are zero.
- `keep_header`  out  B  valid lanes of `data_header`.

## Operation
- **State machine:** IDLE, HDR, BODY, FLUSH.
- **IDLE**
  - `ready_cfg` = 1.
  - On `valid_cfg`: latch H, go to HDR.
- **HDR**
  - `ready_in` = `!valid_header && (!valid_out || ready_out)`.
  - On accepting the first beat:
    - Top H bytes go to `data_header` low lanes; `keep_header` is set for lanes that are valid in `keep_in`.
    - Set `valid_header`.
    - Residue = the low B−H bytes of the beat. Residue count R = valid bytes beyond H (0..B−H).
  - If that beat is also `last_in`:
    - R > 0: emit the residue MSB-aligned as a single beat with `last_out` = 1, then go to IDLE.
    - R = 0: emit no payload, go to IDLE.
  - Otherwise go to BODY.
- **BODY**
  - `ready_in` = `!valid_out || ready_out`.
  - Each accepted beat with n valid bytes:
    - Output = {residue (B−H bytes), top H bytes of `data_in`}.
    - New residue = low B−H bytes of `data_in`.
  - On `last_in`, let total = (B−H) + n:
    - total ≤ B: output a single merged beat, `last_out` = 1, `keep_out` = top `total` lanes. Go to IDLE.
    - total > B: output a full beat with `last_out` = 0, then go to FLUSH.
  - H = B degenerates to pass-through: no residue, data unchanged.
- **FLUSH**
  - `ready_in` = 0.
  - When the output register is free, emit the remaining n−H bytes MSB-aligned with `last_out` = 1. Go to IDLE.
- **Header channel**
  - Single-entry register; `valid_header` drops on `ready_header`.
  - Backpressure on the header channel stalls only the first beat of the next packet.
- **Reset** (including mid-packet)
  - Discard any partial packet; go to IDLE.
  - All outputs reset to 0, except `ready_cfg`, which is 1.

## Timing
- Output and header registers are loaded on the input handshake edge.
- Header latency: `valid_header` is high on the cycle after the first beat is accepted.
- Payload latency: the first payload beat is valid the cycle after the second input beat is accepted. A single-beat packet's residue is valid the cycle after that beat is accepted.
- FLUSH adds exactly one output beat, issued once the previous beat has been taken.
- Holding rule: while `valid_out` && !`ready_out`, `data_out`, `keep_out` and `last_out` stay stable. The same holds for the header signals while !`ready_header`.
- Throughput: one beat per cycle with no bubbles while `ready_out` = 1, except the FLUSH cycle.

## Configuration
- Macro: `AXIS_EXTRACT_SHORT_ERR_EN`.
- **Defined:** adds output port `err_short` (1 bit, reset 0).
  - Pulses high for one cycle, together with `valid_header`, when the packet ends before H header bytes have arrived (valid bytes of a `last_in` first beat < H).
- **Undefined:** the port is absent. A short header is still emitted with a partial `keep_header` and no error indication.

## Test plan
All scenarios use B = 4.

1. **Merged last beat.** H=2. Input 0xAABBCCDD/1111, 0x11223344/1111, 0x55667788/1100 last.
   - Header 0x0000AABB, keep 0011.
   - Payload 0xCCDD1122/1111, then 0x33445566/1111 with `last_out`.
2. **Flush beat.** As scenario 1, but last `keep_in` = 1110.
   - Payload 0xCCDD1122, 0x33445566 (not last), then FLUSH 0x77000000/1000 with `last_out`.
3. **Single-beat packet, H=1.** Input 0xAABBCCDD/1111 last.
   - Header 0x000000AA, keep 0001.
   - Payload 0xBBCCDD00/1110 with `last_out`.
4. **Short packet, H=4.** Input 0xAABBCCDD/1100 last.
   - Header 0xAABB0000, keep 1100.
   - No payload beat; `err_short` pulses if the macro is enabled.
5. **Backpressure.** Scenario 1 with `ready_out` and `ready_header` held low for 5 cycles.
   - Outputs stay stable; `ready_in` stays 0; no beat is lost or duplicated.
6. **Reset mid-packet.** Assert `rst_n` low after the second beat of scenario 1.
   - All outputs are 0 and `ready_cfg` = 1.
   - The next packet, H=3, extracts correctly from a clean state.
